bytemask_mem_pipe: RTL and testbench
====================================

Name: bytemask_mem_pipe

Overview:
Parametrised single-port, byte-masked synchronous memory with a valid/ready request channel and a registered read-response channel with backpressure. After reset it runs a hardware zero-initialisation sweep. It is the next generation of the team's byte-masked memory (fixed 32-bit × 256 word, combinational handshake-free), generalised in width/depth and made safe for pipelined masters.

Parameters:
DATA_W, 32, word width in bits; must be a multiple of 8
ADDR_W, 8, address width; depth = 2**ADDR_W words (derived, not a parameter)
INIT_ZERO, 1, 1 = zero every word after reset before accepting requests; 0 = skip the sweep

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
c_en  input  1  chip enable; low = global stall (no accepts, state frozen)
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_wr  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  word address
req_wdata  input  DATA_W  write data
req_wmask  input  DATA_W/8  byte write enables; bit i = 1 writes byte i (bits 8i+7:8i)
resp_valid  output  1  read data valid
resp_ready  input  1  consumer accepts read data
resp_rdata  output  DATA_W  read data
init_done  output  1  high once the zero sweep is complete (or immediately if INIT_ZERO=0)

Behaviour:
- Reset (rst_n low, async): req_ready=0, resp_valid=0, resp_rdata=0, init_done=0, FSM→INIT, sweep counter=0. Memory array is not reset; only the sweep clears it.
- FSM states: INIT, RUN.
- INIT: each cycle with c_en=1, write all-zero to mem[cnt], then cnt+1. After writing word 2**ADDR_W−1 → RUN; init_done=1 from the next cycle. The sweep takes 2**ADDR_W enabled cycles. If INIT_ZERO=0, INIT lasts exactly one cycle and writes nothing. c_en=0 pauses cnt. req_ready=0 throughout INIT.
- RUN: req_ready = c_en & (!resp_valid | resp_ready). Accept = req_valid & req_ready.
- Accepted write: at the same edge, each byte i with req_wmask[i]=1 gets req_wdata byte i; other bytes are unchanged. No response is generated. Mask all-zero: accepted, memory unchanged.
- Accepted read: resp_rdata ← mem[req_addr] and resp_valid ← 1 at the same edge. Latency is 1 cycle. The data reflects every write accepted in earlier cycles, so write-then-read of the same address returns the new value.
- Response hold: while resp_valid=1 & resp_ready=0, resp_valid and resp_rdata are stable and no new request is accepted.
- resp_ready=1 with resp_valid=1: if a read is accepted the same cycle, resp_valid stays 1 with the new data. Otherwise resp_valid→0 (a write accepted that cycle also clears it).
- resp_ready with resp_valid=0: ignored.
- c_en=0 in RUN: req_ready=0, resp_valid/resp_rdata held, memory untouched. resp_ready is not sampled.
- Reset mid-operation: any pending response is dropped, and the FSM restarts INIT (the sweep rezeroes all memory).
- Inputs other than rst_n are ignored while not accepted. Address range is the full 2**ADDR_W, with no out-of-range case.

Test Plan:
1. Reset release, c_en=1, default params → req_ready=0, init_done=0 for 256 cycles, then init_done=1 and req_ready=1; a read of addr 255 returns 0x00000000.
2. Write addr 255 data 0x00000007 mask 4'b0000, then read 255 → 0x00000000. Write 0x00000005 mask 4'b0001, then read 255 → 0x00000005.
3. Write addr 10 data 0xAABBCCDD mask 4'b1111, then write 0x11223344 mask 4'b0101. A read issued back-to-back the next cycle → 0xAA22CC44, resp_valid exactly 1 cycle after accept.
4. Read addr 10 with resp_ready=0 for 3 cycles → resp_valid=1, data 0xAA22CC44 stable, req_ready=0 with a new read pending. resp_ready=1 → new read accepted the same cycle, resp_valid stays 1 with the new data.
5. Assert c_en=0 at sweep count 100 for 5 cycles → init_done still rises only after 256 enabled cycles. Assert c_en=0 in RUN with a response pending → outputs frozen.
6. Drop rst_n mid-response and after writing addr 10 → resp_valid=0 immediately. After the new sweep, a read of addr 10 returns 0. Repeat with INIT_ZERO=0 → init_done=1 one cycle after reset release.

Source files
------------

// File: rtl/bytemask_mem_pipe.sv
// Byte-masked single-port memory with valid/ready requests,
// registered read responses and a post-reset zero sweep.
module bytemask_mem_pipe #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int INIT_ZERO = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                c_en,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wmask,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                init_done
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t              r_state;
  state_t              w_state_d;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   w_cnt_d;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic                r_rv;
  logic [DATA_W-1:0]   r_rd;

  logic w_run;
  logic w_acc;
  logic w_rd;
  logic w_wr;
  logic w_init_wr;

  assign w_run     = (r_state == S_RUN);
  assign req_ready = w_run & c_en & (~r_rv | resp_ready);
  assign w_acc     = req_valid & req_ready;
  assign w_rd      = w_acc & ~req_wr;
  assign w_wr      = w_acc & req_wr;
  assign w_init_wr = ~w_run & c_en & (INIT_ZERO != 0);

  assign resp_valid = r_rv;
  assign resp_rdata = r_rd;
  assign init_done  = w_run;

  // Without a sweep, INIT is a single enabled cycle.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    if (!w_run && c_en) begin
      w_cnt_d = r_cnt + 1'b1;
      if (INIT_ZERO == 0 || r_cnt == '1) begin
        w_state_d = S_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_init_wr) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (req_wmask[i]) begin
          r_mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rv <= 1'b0;
      r_rd <= '0;
    end else if (w_run && c_en) begin
      if (w_rd) begin
        r_rv <= 1'b1;
        r_rd <= r_mem[req_addr];
      end else if (resp_ready) begin
        r_rv <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bytemask_mem_pipe.sv
// Bench for bytemask_mem_pipe: vector table, corner
// sequences and a randomized run against a memory model.
module tb_bytemask_mem_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_en;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        init_done;

  logic        z_req_ready;
  logic        z_resp_valid;
  logic [31:0] z_resp_rdata;
  logic        z_init_done;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] mem [256];
  logic        m_valid;
  logic [31:0] m_data;

  always #5 clk = ~clk;

  bytemask_mem_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .c_en       (c_en),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .init_done  (init_done)
  );

  bytemask_mem_pipe #(
    .DATA_W    (32),
    .ADDR_W    (8),
    .INIT_ZERO (0)
  ) dut_nz (
    .clk        (clk),
    .rst_n      (rst_n),
    .c_en       (c_en),
    .req_valid  (req_valid),
    .req_ready  (z_req_ready),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .resp_valid (z_resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (z_resp_rdata),
    .init_done  (z_init_done)
  );

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [7];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mwrite(input logic [7:0] a,
                        input logic [31:0] d,
                        input logic [3:0] m);
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        mem[a] = (mem[a] & ~(32'hFF << (8*i)))
               | (d & (32'hFF << (8*i)));
      end
    end
  endtask

  // Runs one post-reset sweep; optionally stalls 5 cycles
  // once 'pause_at' enabled cycles have elapsed.
  task automatic sweep(input int pause_at);
    int  en_cnt;
    int  paused;
    bit  low_ok;
    bit  first;
    en_cnt = 0;
    paused = 0;
    low_ok = 1'b1;
    first  = 1'b1;
    req_valid = 1'b0;
    while (en_cnt < 256) begin
      if (en_cnt == pause_at && paused < 5) begin
        c_en = 1'b0;
        paused++;
      end else begin
        c_en = 1'b1;
        en_cnt++;
      end
      step();
      if (first) begin
        chk("nz_init_done_1cyc", z_init_done, 1'b1);
        first = 1'b0;
      end
      if (en_cnt < 256 && (init_done || req_ready)) begin
        low_ok = 1'b0;
      end
    end
    chk("init_low_during_sweep", low_ok, 1'b1);
    chk("init_done_after_sweep", init_done, 1'b1);
    chk("req_ready_after_sweep", req_ready, 1'b1);
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask

  initial begin
    vt[0] = '{1'b1, 8'd255, 32'h7, 4'b0000, 32'h0};
    vt[1] = '{1'b0, 8'd255, 32'h0, 4'b0000, 32'h0};
    vt[2] = '{1'b1, 8'd255, 32'h5, 4'b0001, 32'h0};
    vt[3] = '{1'b0, 8'd255, 32'h0, 4'b0000, 32'h5};
    vt[4] = '{1'b1, 8'd10, 32'hAABBCCDD, 4'b1111, 32'h0};
    vt[5] = '{1'b1, 8'd10, 32'h11223344, 4'b0101, 32'h0};
    vt[6] = '{1'b0, 8'd10, 32'h0, 4'b0000, 32'hAA22CC44};

    rst_n      = 1'b0;
    c_en       = 1'b1;
    req_valid  = 1'b0;
    req_wr     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_wmask  = '0;
    resp_ready = 1'b1;
    m_valid    = 1'b0;
    m_data     = '0;

    step();
    step();
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_nz_init_done", z_init_done, 1'b0);
    rst_n = 1'b1;
    sweep(-1);

    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 8'd255;
    step();
    chk("first_rd_valid", resp_valid, 1'b1);
    chk("first_rd_data", resp_rdata, 32'h0);
    req_valid = 1'b0;
    step();

    // Back-to-back table; each read checks 1-cycle latency.
    for (int v = 0; v < 7; v++) begin
      req_valid = 1'b1;
      req_wr    = vt[v].wr;
      req_addr  = vt[v].addr;
      req_wdata = vt[v].data;
      req_wmask = vt[v].mask;
      step();
      if (vt[v].wr) begin
        mwrite(vt[v].addr, vt[v].data, vt[v].mask);
        chk("tbl_wr_no_resp", resp_valid, 1'b0);
      end else begin
        chk("tbl_rd_valid", resp_valid, 1'b1);
        chk("tbl_rd_data", resp_rdata, vt[v].exp);
        chk("tbl_rd_model", resp_rdata, mem[vt[v].addr]);
      end
    end
    req_valid = 1'b0;
    step();
    chk("tbl_resp_clear", resp_valid, 1'b0);

    // Backpressure with a second read pending.
    req_valid  = 1'b1;
    req_wr     = 1'b0;
    req_addr   = 8'd10;
    resp_ready = 1'b0;
    step();
    chk("bp_valid", resp_valid, 1'b1);
    chk("bp_data", resp_rdata, 32'hAA22CC44);
    req_addr = 8'd255;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_req_ready", req_ready, 1'b0);
      step();
      chk("bp_hold_valid", resp_valid, 1'b1);
      chk("bp_hold_data", resp_rdata, 32'hAA22CC44);
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_release_ready", req_ready, 1'b1);
    step();
    chk("bp_new_valid", resp_valid, 1'b1);
    chk("bp_new_data", resp_rdata, 32'h5);
    req_valid = 1'b0;
    step();
    chk("bp_drain", resp_valid, 1'b0);

    // Global stall with a response pending.
    req_valid  = 1'b1;
    req_addr   = 8'd10;
    resp_ready = 1'b0;
    step();
    chk("stall_pre_valid", resp_valid, 1'b1);
    c_en       = 1'b0;
    resp_ready = 1'b1;
    req_wr     = 1'b1;
    req_wdata  = 32'hFFFFFFFF;
    req_wmask  = 4'hF;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_req_ready", req_ready, 1'b0);
      step();
      chk("stall_valid", resp_valid, 1'b1);
      chk("stall_data", resp_rdata, 32'hAA22CC44);
    end
    c_en      = 1'b1;
    req_valid = 1'b0;
    step();
    chk("stall_drain", resp_valid, 1'b0);
    req_valid = 1'b1;
    req_wr    = 1'b0;
    step();
    chk("stall_mem_kept", resp_rdata, 32'hAA22CC44);
    req_valid = 1'b0;
    step();
    chk("pre_rnd_idle", resp_valid, 1'b0);

    m_valid = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic rdy;
      logic acc;
      c_en       = ($urandom_range(9) != 0);
      req_valid  = $urandom_range(1);
      req_wr     = $urandom_range(1);
      req_addr   = 8'($urandom_range(15));
      req_wdata  = $urandom;
      req_wmask  = 4'($urandom_range(15));
      resp_ready = $urandom_range(1);
      #1;
      rdy = c_en && (!m_valid || resp_ready);
      chk("rnd_req_ready", req_ready, rdy);
      acc = req_valid && rdy;
      if (c_en) begin
        if (acc && !req_wr) begin
          m_valid = 1'b1;
          m_data  = mem[req_addr];
        end else if (resp_ready) begin
          m_valid = 1'b0;
        end
      end
      if (acc && req_wr) mwrite(req_addr, req_wdata, req_wmask);
      step();
      chk("rnd_resp_valid", resp_valid, m_valid);
      if (m_valid) chk("rnd_resp_data", resp_rdata, m_data);
    end

    // Reset mid-response, then a stalled re-sweep.
    c_en       = 1'b1;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    step();
    req_valid  = 1'b1;
    req_wr     = 1'b1;
    req_addr   = 8'd10;
    req_wdata  = 32'hDEADBEEF;
    req_wmask  = 4'hF;
    step();
    req_wr     = 1'b0;
    resp_ready = 1'b0;
    step();
    chk("r2_pre_valid", resp_valid, 1'b1);
    chk("r2_pre_data", resp_rdata, 32'hDEADBEEF);
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("r2_async_valid", resp_valid, 1'b0);
    chk("r2_async_rdata", resp_rdata, 32'h0);
    chk("r2_async_ready", req_ready, 1'b0);
    chk("r2_async_init", init_done, 1'b0);
    chk("r2_async_nz_init", z_init_done, 1'b0);
    step();
    resp_ready = 1'b1;
    rst_n      = 1'b1;
    sweep(100);
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 8'd10;
    step();
    chk("r2_rd_valid", resp_valid, 1'b1);
    chk("r2_rd_zero", resp_rdata, 32'h0);
    req_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
